// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a 2-entry skid buffer and synchronous flush.
// Define PIPE_STAGE_STATS_EN to add saturating stall_cnt / flush_cnt statistics ports.
module pipe_stage_skid #(
    parameter int WIDTH           = 64,
    parameter bit ZERO_WHEN_EMPTY = 1'b1,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire, out_fire;

    if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
        $error("pipe_stage_skid: WIDTH and CNT_W must be at least 1");
    end

    // in_ready depends on state only, so out_ready never reaches upstream combinationally.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path infers a latch.
        state_next = state;
        main_d     = main_q;
        skid_d     = skid_q;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_next = ONE;
                        main_d     = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_next = FULL;
                        skid_d     = in_data;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    // Skid entry is always the younger one; it moves up when main drains.
                    if (out_fire) begin
                        state_next = ONE;
                        main_d     = skid_q;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: data registers are reset too, because out_data must read 0 straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    if (ZERO_WHEN_EMPTY) begin : g_zero_out
        assign out_data = out_valid ? main_q : '0;
    end else begin : g_hold_out
        assign out_data = main_q;
    end

`ifdef PIPE_STAGE_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush && state != EMPTY && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed cases on a 32-bit instance, then
// randomised traffic on 32-bit and 97-bit instances against a queue-based reference model.
module tb_pipe_stage_skid;

    localparam int WA = 32;
    localparam int WB = 97;
    localparam int CA = 16;
    localparam int CB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          a_flush = 0, a_in_valid = 0, a_out_ready = 0;
    logic          a_in_ready, a_out_valid;
    logic [WA-1:0] a_in_data = '0, a_out_data;
    logic          b_flush = 0, b_in_valid = 0, b_out_ready = 0;
    logic          b_in_ready, b_out_valid;
    logic [WB-1:0] b_in_data = '0, b_out_data;
`ifdef PIPE_STAGE_STATS_EN
    logic [CA-1:0] a_stall_cnt, a_flush_cnt;
    logic [CB-1:0] b_stall_cnt, b_flush_cnt;
`endif

    pipe_stage_skid #(.WIDTH(WA), .ZERO_WHEN_EMPTY(1'b1), .CNT_W(CA)) u_dut_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
`ifdef PIPE_STAGE_STATS_EN
        , .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
`endif
    );

    pipe_stage_skid #(.WIDTH(WB), .ZERO_WHEN_EMPTY(1'b1), .CNT_W(CB)) u_dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
`ifdef PIPE_STAGE_STATS_EN
        , .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Reference model: the stage is a FIFO of depth 2; flush empties it.
    logic [WA-1:0] q_a[$];
    logic [WB-1:0] q_b[$];
    int stall_a = 0, flush_a = 0, stall_b = 0, flush_b = 0;

    function automatic int sat_inc(input int v, input int max_v);
        return (v < max_v) ? v + 1 : v;
    endfunction

    initial begin
        logic          fire_in_a, fire_out_a, fire_in_b, fire_out_b;
        logic          stalled_a, stalled_b;
        logic [WA-1:0] prev_a;
        logic [WB-1:0] prev_b;
        logic [127:0]  rnd;
        logic [WA-1:0] exp_a;
        logic [WB-1:0] exp_b;

        // Reset held for two cycles
        repeat (2) cyc();
        check("rst_out_valid", a_out_valid, 0);
        check("rst_in_ready", a_in_ready, 1);
        check("rst_out_data", a_out_data, 0);
        check("rst_b_out_data", b_out_data, 0);
        rst = 0;

        // Streaming with out_ready=1: no bubbles
        a_out_ready = 1; a_in_valid = 1; a_in_data = 32'h11;
        check("stream_in_ready0", a_in_ready, 1);
        cyc();
        check("stream_d0", a_out_data, 32'h11);
        check("stream_v0", a_out_valid, 1);
        check("stream_in_ready1", a_in_ready, 1);
        a_in_data = 32'h22;
        cyc();
        check("stream_d1", a_out_data, 32'h22);
        check("stream_in_ready2", a_in_ready, 1);
        a_in_data = 32'h33;
        cyc();
        check("stream_d2", a_out_data, 32'h33);
        a_in_valid = 0;
        cyc();
        check("stream_drained", a_out_valid, 0);

        // Backpressure fill
        a_out_ready = 0; a_in_valid = 1; a_in_data = 32'hA1;
        cyc();
        check("bp_one_in_ready", a_in_ready, 1);
        check("bp_one_data", a_out_data, 32'hA1);
        a_in_data = 32'hA2;
        cyc();
        check("bp_full_in_ready", a_in_ready, 0);
        check("bp_full_data", a_out_data, 32'hA1);
        a_in_valid = 0;
        cyc();
        check("bp_hold_data", a_out_data, 32'hA1);
        a_out_ready = 1;
        cyc();
        check("bp_drain1_data", a_out_data, 32'hA2);
        check("bp_drain1_in_ready", a_in_ready, 1);
        cyc();
        check("bp_drain2_valid", a_out_valid, 0);

        // Flush while FULL
        a_out_ready = 0; a_in_valid = 1; a_in_data = 32'hB1;
        cyc();
        a_in_data = 32'hB2;
        cyc();
        a_in_valid = 0;
        check("fl_full_in_ready", a_in_ready, 0);
        a_flush = 1;
        cyc();
        a_flush = 0;
        check("fl_full_valid", a_out_valid, 0);
        check("fl_full_in_ready_after", a_in_ready, 1);
        check("fl_full_data", a_out_data, 0);
`ifdef PIPE_STAGE_STATS_EN
        check("fl_full_flush_cnt", a_flush_cnt, 1);
`endif

        // Flush with simultaneous input: neither C1 nor C2 may emerge
        a_in_valid = 1; a_in_data = 32'hC1;
        cyc();
        a_in_data = 32'hC2; a_flush = 1;
        check("fl_in_in_ready", a_in_ready, 1);
        cyc();
        a_flush = 0; a_in_valid = 0; a_out_ready = 1;
        check("fl_in_valid0", a_out_valid, 0);
        cyc();
        check("fl_in_valid1", a_out_valid, 0);
        check("fl_in_data1", a_out_data, 0);

        // Asynchronous reset while FULL, observed before the next rising edge
        a_out_ready = 0; a_in_valid = 1; a_in_data = 32'hD1;
        cyc();
        a_in_data = 32'hD2;
        cyc();
        a_in_valid = 0;
        check("ar_full", a_in_ready, 0);
        #1 rst = 1;
        #1;
        check("ar_out_valid", a_out_valid, 0);
        check("ar_in_ready", a_in_ready, 1);
        check("ar_out_data", a_out_data, 0);
`ifdef PIPE_STAGE_STATS_EN
        check("ar_flush_cnt", a_flush_cnt, 0);
`endif
        cyc();
        cyc();
        rst = 0;

        // Randomised traffic on both instances
        stalled_a = 0; stalled_b = 0; prev_a = '0; prev_b = '0;
        for (int cyc_i = 0; cyc_i < 10000; cyc_i++) begin
            exp_a = (q_a.size() > 0) ? q_a[0] : '0;
            exp_b = (q_b.size() > 0) ? q_b[0] : '0;
            check("rnd_a_valid", a_out_valid, q_a.size() > 0);
            check("rnd_a_ready", a_in_ready, q_a.size() < 2);
            check("rnd_a_data", a_out_data, exp_a);
            check("rnd_b_valid", b_out_valid, q_b.size() > 0);
            check("rnd_b_ready", b_in_ready, q_b.size() < 2);
            check("rnd_b_data", b_out_data, exp_b);
            if (stalled_a) check("rnd_a_stable", a_out_data, prev_a);
            if (stalled_b) check("rnd_b_stable", b_out_data, prev_b);
`ifdef PIPE_STAGE_STATS_EN
            check("rnd_a_stall_cnt", a_stall_cnt, stall_a);
            check("rnd_a_flush_cnt", a_flush_cnt, flush_a);
            check("rnd_b_stall_cnt", b_stall_cnt, stall_b);
            check("rnd_b_flush_cnt", b_flush_cnt, flush_b);
`endif
            a_in_valid  = ($urandom_range(9) < 7);
            a_out_ready = ($urandom_range(9) < 6);
            a_flush     = ($urandom_range(49) == 0);
            a_in_data   = $urandom;
            b_in_valid  = ($urandom_range(9) < 5);
            b_out_ready = ($urandom_range(9) < 4);
            b_flush     = ($urandom_range(63) == 0);
            rnd         = {$urandom, $urandom, $urandom, $urandom};
            b_in_data   = rnd[WB-1:0];

            fire_in_a  = a_in_valid && (q_a.size() < 2);
            fire_out_a = a_out_ready && (q_a.size() > 0);
            fire_in_b  = b_in_valid && (q_b.size() < 2);
            fire_out_b = b_out_ready && (q_b.size() > 0);
            stalled_a  = (q_a.size() > 0) && !a_out_ready && !a_flush;
            stalled_b  = (q_b.size() > 0) && !b_out_ready && !b_flush;
            prev_a     = a_out_data;
            prev_b     = b_out_data;
            if (q_a.size() > 0 && !a_out_ready) stall_a = sat_inc(stall_a, (1 << CA) - 1);
            if (q_b.size() > 0 && !b_out_ready) stall_b = sat_inc(stall_b, (1 << CB) - 1);
            if (a_flush && q_a.size() > 0) flush_a = sat_inc(flush_a, (1 << CA) - 1);
            if (b_flush && q_b.size() > 0) flush_b = sat_inc(flush_b, (1 << CB) - 1);

            @(posedge clk);
            if (a_flush) begin
                q_a.delete();
            end else begin
                if (fire_out_a) void'(q_a.pop_front());
                if (fire_in_a) q_a.push_back(a_in_data);
            end
            if (b_flush) begin
                q_b.delete();
            end else begin
                if (fire_out_b) void'(q_b.pop_front());
                if (fire_in_b) q_b.push_back(b_in_data);
            end
            cyc();
        end

`ifdef PIPE_STAGE_STATS_EN
        check("rnd_b_stall_saturated", b_stall_cnt, 15);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
